// File: rtl/fir_pkg.sv
// Shared fixed-point helpers for the FIR filter family.
// Width derivation, rounding and saturation used by all variants.
package fir_pkg;

  localparam int DEF_TAPS   = 7;
  localparam int DEF_XW     = 8;
  localparam int DEF_X_FRAC = 3;
  localparam int DEF_CW     = 8;
  localparam int DEF_C_FRAC = 6;
  localparam int DEF_YW     = 8;
  localparam int DEF_Y_FRAC = 3;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] y;
  } conv_t;

  function automatic int acc_width(
    input int xw,
    input int cw,
    input int n
  );
    return xw + cw + $clog2(n);
  endfunction

  function automatic int shift_amt(
    input int xf,
    input int cf,
    input int yf
  );
    return xf + cf - yf;
  endfunction

  // Round half up, then clip into a signed yw-bit range.
  function automatic conv_t round_sat(
    input logic signed [63:0] acc,
    input int                 sh,
    input int                 yw
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    conv_t o;
    r = acc;
    if (sh > 0)
      r = (acc + (64'sd1 <<< (sh - 1))) >>> sh;
    hi = (64'sd1 <<< (yw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    o.sat = 1'b0;
    o.y   = r;
    if (r > hi) begin
      o.y   = hi;
      o.sat = 1'b1;
    end else if (r < lo) begin
      o.y   = lo;
      o.sat = 1'b1;
    end
    return o;
  endfunction

endpackage

// File: rtl/fir_tf_tap.sv
// One transposed-form stage: partial sum of the next stage
// plus this tap's product, registered on each accepted sample.
module fir_tf_tap
  import fir_pkg::*;
#(
  parameter int XW   = DEF_XW,
  parameter int CW   = DEF_CW,
  parameter int ACCW = 19
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic signed [XW-1:0]   x,
  input  logic signed [CW-1:0]   c,
  input  logic signed [ACCW-1:0] s_in,
  output logic signed [ACCW-1:0] s_out
);

  logic signed [XW+CW-1:0] prod;

  assign prod = x * c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      s_out <= '0;
    else if (clr)
      s_out <= '0;
    else if (en)
      s_out <= s_in + ACCW'(prod);
  end

endmodule

// File: rtl/fir_tf_param.sv
// Parametrised signed transposed-form FIR with shadow/active
// coefficient banks, round-half-up and output saturation.
module fir_tf_param
  import fir_pkg::*;
#(
  parameter int N_TAPS = DEF_TAPS,
  parameter int XW     = DEF_XW,
  parameter int X_FRAC = DEF_X_FRAC,
  parameter int CW     = DEF_CW,
  parameter int C_FRAC = DEF_C_FRAC,
  parameter int YW     = DEF_YW,
  parameter int Y_FRAC = DEF_Y_FRAC
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       In_Valid,
  input  logic signed [XW-1:0]       Xin,
  input  logic                       Clear,
  input  logic                       Coef_Wr,
  input  logic [$clog2(N_TAPS)-1:0]  Coef_Addr,
  input  logic signed [CW-1:0]       Coef_Data,
  input  logic                       Coef_Commit,
  output logic                       Out_Valid,
  output logic signed [YW-1:0]       Yout,
  output logic                       Sat_Flag
);

  localparam int ACCW = acc_width(XW, CW, N_TAPS);
  localparam int SH   = shift_amt(X_FRAC, C_FRAC, Y_FRAC);

  logic signed [CW-1:0]    shadow [N_TAPS];
  logic signed [CW-1:0]    active [N_TAPS];
  logic signed [ACCW-1:0]  s [1:N_TAPS];
  logic signed [XW+CW-1:0] prod0;
  logic signed [ACCW-1:0]  acc0;
  conv_t                   conv;
  logic                    unused_hi;

  // Commit copies pre-write shadow: NBA reads old contents.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < N_TAPS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (Coef_Commit)
        for (int i = 0; i < N_TAPS; i++)
          active[i] <= shadow[i];
      if (Coef_Wr && int'(Coef_Addr) < N_TAPS)
        shadow[Coef_Addr] <= Coef_Data;
    end
  end

  assign s[N_TAPS] = '0;

  for (genvar k = 1; k < N_TAPS; k++) begin : g_tap
    fir_tf_tap #(
      .XW   (XW),
      .CW   (CW),
      .ACCW (ACCW)
    ) u_tap (
      .clk   (Clk),
      .rst_n (Rst_n),
      .en    (In_Valid),
      .clr   (Clear),
      .x     (Xin),
      .c     (active[k]),
      .s_in  (s[k+1]),
      .s_out (s[k])
    );
  end

  assign prod0     = Xin * active[0];
  assign acc0      = s[1] + ACCW'(prod0);
  assign conv      = round_sat(64'(acc0), SH, YW);
  assign unused_hi = ^conv.y[63:YW];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Out_Valid <= 1'b0;
      Yout      <= '0;
      Sat_Flag  <= 1'b0;
    end else if (Clear) begin
      Out_Valid <= 1'b0;
      Yout      <= '0;
      Sat_Flag  <= 1'b0;
    end else begin
      Out_Valid <= In_Valid;
      if (In_Valid) begin
        Yout     <= conv.y[YW-1:0];
        Sat_Flag <= conv.sat;
      end
    end
  end

endmodule

// File: tb/tb_fir_tf_param.sv
// Scoreboard bench for fir_tf_param: directed vectors with
// hand-computed outputs, checked by an independent monitor.
module tb_fir_tf_param;

  logic              Clk;
  logic              Rst_n;
  logic              In_Valid;
  logic signed [7:0] Xin;
  logic              Clear;
  logic              Coef_Wr;
  logic [2:0]        Coef_Addr;
  logic signed [7:0] Coef_Data;
  logic              Coef_Commit;
  logic              Out_Valid;
  logic signed [7:0] Yout;
  logic              Sat_Flag;

  typedef struct {
    logic signed [7:0] y;
    logic              sat;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   passed = 0;
  int   total  = 0;

  fir_tf_param dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .In_Valid    (In_Valid),
    .Xin         (Xin),
    .Clear       (Clear),
    .Coef_Wr     (Coef_Wr),
    .Coef_Addr   (Coef_Addr),
    .Coef_Data   (Coef_Data),
    .Coef_Commit (Coef_Commit),
    .Out_Valid   (Out_Valid),
    .Yout        (Yout),
    .Sat_Flag    (Sat_Flag)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(negedge Clk) begin
    if (Rst_n && Out_Valid) begin
      total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_output y=%0d sat=%0b none expected",
                 Yout, Sat_Flag);
      end else begin
        e = q.pop_front();
        if (Yout === e.y && Sat_Flag === e.sat)
          passed++;
        else
          $display("FAIL yout got y=%0d sat=%0b want y=%0d sat=%0b",
                   Yout, Sat_Flag, e.y, e.sat);
      end
    end
  end

  task automatic chk(input string n, input int got, input int want);
    total++;
    if (got == want)
      passed++;
    else
      $display("FAIL %s got=%0d want=%0d", n, got, want);
  endtask

  task automatic push(input int y, input int sat);
    exp_t t;
    t.y   = y[7:0];
    t.sat = sat[0];
    q.push_back(t);
  endtask

  task automatic send(input int x, input int y, input int sat);
    In_Valid = 1'b1;
    Xin      = x[7:0];
    push(y, sat);
    @(posedge Clk); #1;
    In_Valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    Coef_Wr   = 1'b1;
    Coef_Addr = a[2:0];
    Coef_Data = d[7:0];
    @(posedge Clk); #1;
    Coef_Wr = 1'b0;
  endtask

  task automatic commit();
    Coef_Commit = 1'b1;
    @(posedge Clk); #1;
    Coef_Commit = 1'b0;
  endtask

  task automatic load(input int c [7]);
    for (int i = 0; i < 7; i++)
      wr(i, c[i]);
    commit();
  endtask

  // Clear with a simultaneous sample that must be dropped.
  task automatic clear_cycle();
    Clear    = 1'b1;
    In_Valid = 1'b1;
    Xin      = 8'sd5;
    @(posedge Clk); #1;
    Clear    = 1'b0;
    In_Valid = 1'b0;
    chk("clear_yout", Yout, 0);
    chk("clear_sat", Sat_Flag, 0);
  endtask

  task automatic impulse(input int gap);
    send(8, 1, 0);
    for (int k = 2; k <= 7; k++) begin
      idle(gap);
      send(0, k, 0);
    end
    idle(gap);
    send(0, 0, 0);
  endtask

  initial begin
    Rst_n       = 1'b0;
    In_Valid    = 1'b0;
    Xin         = '0;
    Clear       = 1'b0;
    Coef_Wr     = 1'b0;
    Coef_Addr   = '0;
    Coef_Data   = '0;
    Coef_Commit = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_valid", Out_Valid, 0);
    chk("rst_yout", Yout, 0);
    chk("rst_sat", Sat_Flag, 0);
    Rst_n = 1'b1;
    idle(1);

    // impulse, back-to-back; addr 7 must be ignored
    wr(7, 127);
    load('{8, 16, 24, 32, 40, 48, 56});
    impulse(0);

    // same impulse with idle gaps
    impulse(3);

    // saturation both ways
    load('{127, 127, 127, 127, 127, 127, 127});
    for (int i = 0; i < 7; i++)
      send(127, 127, 1);
    send(-128, 127, 1);
    send(-128, 127, 1);
    send(-128, 127, 1);
    for (int i = 0; i < 5; i++)
      send(-128, -128, 1);
    clear_cycle();

    // rounding, half rounds up
    load('{32, 0, 0, 0, 0, 0, 0});
    send(1, 1, 0);
    send(-1, 0, 0);
    send(3, 2, 0);
    send(-3, -1, 0);

    // commit racing a sample and a shadow write
    load('{8, 16, 24, 32, 40, 48, 56});
    clear_cycle();
    wr(1, 64);
    for (int i = 2; i < 7; i++)
      wr(i, 0);
    send(8, 1, 0);
    Coef_Wr     = 1'b1;
    Coef_Addr   = 3'd0;
    Coef_Data   = 8'sd64;
    Coef_Commit = 1'b1;
    send(8, 3, 0);
    Coef_Wr     = 1'b0;
    Coef_Commit = 1'b0;
    send(8, 6, 0);
    send(0, 15, 0);
    send(0, 9, 0);
    commit();
    send(8, 19, 0);
    send(0, 21, 0);
    send(0, 7, 0);
    send(0, 0, 0);

    // asynchronous reset mid-burst
    load('{8, 16, 24, 32, 40, 48, 56});
    clear_cycle();
    send(8, 1, 0);
    send(0, 2, 0);
    In_Valid = 1'b1;
    Xin      = 8'sd8;
    @(posedge Clk); #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_valid", Out_Valid, 0);
    chk("arst_yout", Yout, 0);
    chk("arst_sat", Sat_Flag, 0);
    In_Valid = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    idle(1);
    send(8, 0, 0);
    send(0, 0, 0);

    // clear mid-burst keeps coefficients
    load('{8, 16, 24, 32, 40, 48, 56});
    send(8, 1, 0);
    send(8, 3, 0);
    send(8, 6, 0);
    clear_cycle();
    impulse(0);

    idle(3);
    chk("sb_drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
